policy_fifo_sync: RTL and testbench

Single-clock, parametrised FIFO that supports both a blocking full policy and an overwrite-oldest full policy, selected per instance. It adds programmable almost-full/almost-empty thresholds, a synchronous flush, overflow/underflow strobes and a saturating drop counter. It is the buffering stage between the UART-lite byte engines and the bus-side register file. It is also the general-purpose small FIFO for other peripherals needing a "latest N samples" or lossless queue.

---
 rtl/fifo_pkg.sv | 8 +
 rtl/fifo_mem_sp.sv | 17 +
 rtl/policy_fifo_sync.sv | 76 +++++++
 tb/tb_policy_fifo_sync.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: FIFO policy encodings and the pointer-width helper shared by FIFOs.
package fifo_pkg;
  localparam int FIFO_POLICY_BLOCK = 0;
  localparam int FIFO_POLICY_OVERWRITE = 1;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem_sp.sv
// fifo_mem_sp: WIDTH x DEPTH register array, synchronous write, asynchronous read, no reset.
module fifo_mem_sp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk_i)
    if (we_i) mem[waddr_i] <= wdata_i;
  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/policy_fifo_sync.sv
// policy_fifo_sync: single-clock FIFO with blocking or overwrite-oldest full policy, thresholds, flush and drop counter.
module policy_fifo_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 4,
  parameter int OVERWRITE     = FIFO_POLICY_BLOCK,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  parameter int DROP_W        = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      wr_i,
  input  logic [WIDTH-1:0]          data_i,
  input  logic                      rd_i,
  output logic [WIDTH-1:0]          data_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic                      almost_empty_o,
  output logic                      almost_full_o,
  output logic [ptr_w(DEPTH)-1:0]   count_o,
  output logic                      overflow_o,
  output logic                      underflow_o,
  output logic [DROP_W-1:0]         drop_cnt_o
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("policy_fifo_sync: DEPTH must be a power of two >= 2");
  end
  logic [PW-1:0] wptr, rptr, count_nxt;
  logic full_hit, do_wr, do_rd, adv_r;
  // A write into a full FIFO without a simultaneous pop is the only overflow case.
  always_comb begin
    full_hit  = wr_i && full_o && !rd_i;
    do_wr     = wr_i && (!full_hit || OVERWRITE != FIFO_POLICY_BLOCK);
    do_rd     = rd_i && !empty_o;
    adv_r     = do_rd || (do_wr && full_hit);
    count_nxt = count_o + PW'(do_wr && !adv_r) - PW'(adv_r && !do_wr);
  end
  fifo_mem_sp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk_i   (clk_i),
    .we_i    (do_wr && rst_ni && !clear_i),
    .waddr_i (wptr[AW-1:0]),
    .wdata_i (data_i),
    .raddr_i (rptr[AW-1:0]),
    .rdata_o (data_o)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      wptr           <= '0;
      rptr           <= '0;
      count_o        <= '0;
      empty_o        <= 1'b1;
      full_o         <= 1'b0;
      almost_empty_o <= 1'b1;
      almost_full_o  <= 1'b0;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
      if (!rst_ni) drop_cnt_o <= '0;
    end else begin
      wptr           <= wptr + PW'(do_wr);
      rptr           <= rptr + PW'(adv_r);
      count_o        <= count_nxt;
      empty_o        <= count_nxt == '0;
      full_o         <= count_nxt == PW'(DEPTH);
      almost_empty_o <= count_nxt <= PW'(AEMPTY_THRESH);
      almost_full_o  <= count_nxt >= PW'(AFULL_THRESH);
      overflow_o     <= full_hit;
      underflow_o    <= rd_i && empty_o;
      if (full_hit && !(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + DROP_W'(1);
    end
  end
endmodule

// File: tb/tb_policy_fifo_sync.sv
// tb_policy_fifo_sync: several FIFO configurations share one stimulus stream, each checked against a queue model.
module tb_policy_fifo_sync;
  localparam int NI = 7;
  function automatic int dep(input int i);
    return (i < 3) ? 4 : (i < 5) ? 2 : 16;
  endfunction
  function automatic int ow(input int i);
    return (i == 1 || i == 4 || i == 6) ? 1 : 0;
  endfunction
  function automatic int dw(input int i);
    return (i == 2) ? 2 : 8;
  endfunction
  logic clk = 1'b0;
  logic rst_n, clr, wr, rd;
  logic [7:0] din;
  logic [7:0] dout [NI];
  logic [4:0] cnt [NI];
  logic [7:0] drop [NI];
  logic emp [NI], ful [NI], ae [NI], af [NI], ovf [NI], udf [NI];
  always #5 clk = ~clk;
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D = dep(g);
    localparam int W = dw(g);
    logic [$clog2(D):0] c;
    logic [W-1:0] dc;
    policy_fifo_sync #(.WIDTH(8), .DEPTH(D), .OVERWRITE(ow(g)), .DROP_W(W)) u_dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .clear_i        (clr),
      .wr_i           (wr),
      .data_i         (din),
      .rd_i           (rd),
      .data_o         (dout[g]),
      .empty_o        (emp[g]),
      .full_o         (ful[g]),
      .almost_empty_o (ae[g]),
      .almost_full_o  (af[g]),
      .count_o        (c),
      .overflow_o     (ovf[g]),
      .underflow_o    (udf[g]),
      .drop_cnt_o     (dc)
    );
    assign cnt[g]  = 5'(c);
    assign drop[g] = 8'(dc);
  end
  logic [7:0] q [NI][$];
  int md [NI];
  bit mo [NI], mu [NI];
  int errs = 0, checks = 0, cur = 0;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s inst=%0d got=%0h exp=%0h at %0t", tag, cur, got, exp, $time);
    end
  endtask
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      bit e, f;
      e = q[i].size() == 0;
      f = q[i].size() == dep(i);
      if (!rst_n) begin
        q[i].delete(); md[i] = 0; mo[i] = 0; mu[i] = 0;
      end else if (clr) begin
        q[i].delete(); mo[i] = 0; mu[i] = 0;
      end else begin
        mo[i] = wr && f && !rd;
        mu[i] = rd && e;
        if (rd && !e) void'(q[i].pop_front());
        if (wr && !(mo[i] && ow(i) == 0)) begin
          if (mo[i]) void'(q[i].pop_front());
          q[i].push_back(din);
        end
        if (mo[i] && md[i] < (1 << dw(i)) - 1) md[i]++;
      end
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      int n, d;
      n = q[i].size();
      d = dep(i);
      cur = i;
      chk("count", int'(cnt[i]), n);
      chk("empty", int'(emp[i]), int'(n == 0));
      chk("full", int'(ful[i]), int'(n == d));
      chk("aempty", int'(ae[i]), int'(n <= 1));
      chk("afull", int'(af[i]), int'(n >= d - 1));
      chk("overflow", int'(ovf[i]), int'(mo[i]));
      chk("underflow", int'(udf[i]), int'(mu[i]));
      chk("drop", int'(drop[i]), md[i]);
      if (n > 0) chk("data", int'(dout[i]), int'(q[i][0]));
    end
  endtask
  task automatic cyc(input logic r, input logic c, input logic w, input logic rr, input logic [7:0] d);
    rst_n = r; clr = c; wr = w; rd = rr; din = d;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask
  task automatic fixed(input int inst, input string tag, input int got, input int exp);
    cur = inst;
    chk(tag, got, exp);
  endtask
  initial begin
    logic [7:0] pat [4];
    pat = '{8'h11, 8'h22, 8'h33, 8'h44};
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    fixed(0, "rst_count", int'(cnt[0]), 0);
    fixed(0, "rst_empty", int'(emp[0]), 1);
    fixed(0, "rst_aempty", int'(ae[0]), 1);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 1, 0, pat[k]);
      if (k == 2) fixed(0, "afull_3rd", int'(af[0]), 1);
    end
    fixed(0, "full_4", int'(ful[0]), 1);
    fixed(0, "count_4", int'(cnt[0]), 4);
    cyc(1, 0, 1, 0, 8'h55);
    fixed(0, "blk_ovf", int'(ovf[0]), 1);
    fixed(0, "blk_drop", int'(drop[0]), 1);
    fixed(0, "blk_head", int'(dout[0]), 8'h11);
    fixed(1, "ow_head", int'(dout[1]), 8'h22);
    fixed(1, "ow_count", int'(cnt[1]), 4);
    fixed(1, "ow_drop", int'(drop[1]), 1);
    cyc(1, 0, 0, 0, 0);
    fixed(0, "ovf_clear", int'(ovf[0]), 0);
    for (int k = 0; k < 4; k++) begin
      fixed(0, "drain_blk", int'(dout[0]), int'(pat[k]));
      fixed(1, "drain_ow", int'(dout[1]), (k + 2) * 8'h11);
      cyc(1, 0, 0, 1, 0);
    end
    fixed(0, "empty_drain", int'(emp[0]), 1);
    cyc(1, 0, 1, 1, 8'h7A);
    fixed(0, "wrrd_count", int'(cnt[0]), 1);
    fixed(0, "wrrd_udf", int'(udf[0]), 1);
    fixed(0, "wrrd_data", int'(dout[0]), 8'h7A);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    fixed(0, "rd_empty_udf", int'(udf[0]), 1);
    fixed(0, "rd_empty_cnt", int'(cnt[0]), 0);
    cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) cyc(1, 0, 1, 0, 8'(k + 1));
    fixed(2, "drop_sat", int'(drop[2]), 3);
    cyc(1, 1, 1, 1, 8'hEE);
    fixed(2, "clr_count", int'(cnt[2]), 0);
    fixed(2, "clr_empty", int'(emp[2]), 1);
    fixed(2, "clr_drop", int'(drop[2]), 3);
    cyc(1, 0, 1, 0, 8'hA5);
    fixed(2, "post_clr_data", int'(dout[2]), 8'hA5);
    cyc(0, 0, 1, 0, 0);
    fixed(2, "rst_drop", int'(drop[2]), 0);
    for (int p = 0; p < 20; p++) begin
      int wp, rp;
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int k = 0; k < 500; k++)
        cyc($urandom_range(0, 255) != 0, $urandom_range(0, 63) == 0,
            $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, 8'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
